fp_mul_err_monitor: RTL and testbench
=====================================

Name: fp_mul_err_monitor

Overview:
- Streaming on-chip error monitor for approximate FP multiplier characterisation.
- Consumes paired exact and approximate multiplier results, one pair per accepted handshake, over a programmable sample window.
- Accumulates ULP-distance statistics in hardware: total error, maximum error, mismatch count and gross-error count.
- Replaces offline dump-and-compare for long sweeps over Conf_Bit_Mask settings; sits between the exact/approx multiplier pair and a CSR read-back path.

Parameters:
- FP_W, 32, floating-point word width (sign + EXP_W + mantissa).
- EXP_W, 8, exponent field width.
- CNT_W, 16, width of window length and all sample counters.
- SUM_W, 48, width of the ULP error accumulator (saturating).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  pulse; begins a new window (honoured only in IDLE or DONE)
- win_len  in  CNT_W  number of samples in the window, sampled on accepted start
- in_valid  in  1  sample pair valid
- in_ready  out  1  monitor can accept a pair
- exact_res  in  FP_W  exact multiplier result
- approx_res  in  FP_W  approximate multiplier result
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse on entry to DONE
- sample_cnt  out  CNT_W  pairs accepted in the current or last window
- mismatch_cnt  out  CNT_W  pairs with bitwise inequality
- gross_cnt  out  CNT_W  pairs not ULP-comparable
- max_err  out  FP_W-1  largest ULP distance seen
- sum_err  out  SUM_W  saturating sum of ULP distances
- sum_sat  out  1  sticky; set when sum_err has saturated

Behaviour:
- Reset: state=IDLE. All outputs 0, including in_ready, done and sum_sat.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start, win_len==0: go to DONE, pulse done, clear all stats to 0.
  - IDLE/DONE + start, win_len>0: clear stats, latch win_len, go to RUN.
  - start in RUN or DRAIN: ignored.
  - RUN: leave when the win_len-th pair is accepted → DRAIN.
  - DRAIN: wait 2 cycles for the pipeline to empty → DONE, pulse done.
  - DONE: stats hold stable until the next start.
- Handshake:
  - in_ready = (state==RUN) && (accepted < latched win_len).
  - A transfer occurs when in_valid && in_ready; in_valid may be held with no ordering requirement.
  - in_ready drops in the same cycle the last pair is accepted (combinational on the count).
- Pipeline, 2 stages:
  - Stage 1 registers the pair and classifies it:
    - gross if exponent is all-ones in either operand (Inf/NaN);
    - gross if signs differ and the pair is not (±0, ±0);
    - mismatch if exact_res != approx_res.
  - Stage 2 updates the stats.
  - For non-gross pairs, d = |exact[FP_W-2:0] − approx[FP_W-2:0]| as an unsigned integer (same-sign IEEE magnitudes are monotonic, so d is the ULP distance). +0 vs −0 gives d=0 and counts as a mismatch.
- sample_cnt increments at stage 1 accept.
- Update rules:
  - sum_err += d, saturating at all-ones; sum_sat sets on the first overflow and is sticky until start.
  - max_err = max(max_err, d).
  - Gross pairs increment gross_cnt (and mismatch_cnt) and contribute nothing to sum_err or max_err.
- Counters: window length is capped by CNT_W, so counters never wrap.
- Statistic outputs are valid when done fires; during RUN/DRAIN they update live.
- Asynchronous reset mid-window aborts the window; everything returns to reset values.

Decomposition:
- Shared package fp_mon_pkg holds:
  - state enum;
  - function fp_is_special(exp field) and function ulp_dist;
  - localparam MAG_W = FP_W-1.
- One sub-module, fp_err_classify: the combinational stage-1 classifier producing gross, mismatch and d. It is reused by later FP16/BF16 monitor variants via the FP_W/EXP_W parameters.

Test Plan:
- Reset with in_valid=1 → in_ready=0, all stats 0, done never pulses.
- start, win_len=3; pairs (3F800000,3F800003), (40000000,40000000), (3F800000,3F7FFFFF) → sample_cnt=3, mismatch_cnt=2, gross_cnt=0, sum_err=4, max_err=3; done pulses once, 2 cycles after the third accept.
- start, win_len=2; pairs (3F800000,BF800000), (7FC00000,3F800000) → gross_cnt=2, mismatch_cnt=2, sum_err=0, max_err=0.
- Zero handling: (00000000,80000000) → mismatch_cnt=1, gross_cnt=0, d=0. Separately, start with win_len=0 → done pulses the cycle after start, all stats 0.
- SUM_W=8, win_len=2; pairs with d=200 each → sum_err=8'hFF, sum_sat=1, max_err=200. A new start clears sum_sat.
- Window 5 with in_valid toggling randomly and a start pulse issued mid-RUN → start ignored, exactly 5 accepts, in_ready low after the 5th. Separately, rst_n asserted after 2 accepts → immediate return to IDLE with zeroed stats.

Source files
------------

// File: rtl/fp_mul_err_monitor_pkg.sv
// -----------------------------------------------------------------------------
// fp_mon_pkg
// Shared definitions for the FP multiplier error monitor family.
//   state_t        : monitor FSM states
//   fp_is_special  : exponent field all-ones test (Inf/NaN), width given at call
//   ulp_dist       : absolute difference of two IEEE magnitudes (widest format)
//   MAG_W          : magnitude width of the default FP32 format
// -----------------------------------------------------------------------------
package fp_mon_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned MAG_W     = FP_W - 1;
    // Widest supported exponent / magnitude, so one function serves every variant.
    localparam int unsigned EXP_MAX_W = 16;
    localparam int unsigned DIST_W    = 63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Only the low exp_w bits of exp_f take part in the test.
    function automatic logic fp_is_special(input logic [EXP_MAX_W-1:0] exp_f,
                                           input int unsigned          exp_w);
        logic all_ones;
        all_ones = 1'b1;
        for (int unsigned i = 0; i < EXP_MAX_W; i++) begin
            if ((i < exp_w) && !exp_f[i]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

    // Same-sign IEEE magnitudes are monotonic integers, so this is the ULP distance.
    function automatic logic [DIST_W-1:0] ulp_dist(input logic [DIST_W-1:0] a,
                                                   input logic [DIST_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fp_mul_err_monitor_if.sv
// -----------------------------------------------------------------------------
// fp_mul_err_monitor_if
// Sample-pair stream into the error monitor.
//   in_valid   : pair valid (source)
//   in_ready   : monitor can accept (sink)
//   exact_res  : exact multiplier result (source)
//   approx_res : approximate multiplier result (source)
// -----------------------------------------------------------------------------
interface fp_mul_err_monitor_if #(
    parameter int unsigned FP_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] exact_res;
    logic [FP_W-1:0] approx_res;

    modport master (output in_valid, output exact_res, output approx_res, input in_ready);
    modport slave  (input in_valid, input exact_res, input approx_res, output in_ready);
endinterface

// File: rtl/fp_mul_err_monitor_classify.sv
// -----------------------------------------------------------------------------
// fp_err_classify
// Combinational classifier for one exact/approximate result pair.
//   exact_res, approx_res : operands (FP_W bits, sign + EXP_W + mantissa)
//   gross                 : pair not ULP-comparable (Inf/NaN, or sign differs
//                           other than +0 vs -0)
//   mismatch              : bitwise inequality
//   d                     : ULP distance of the magnitudes, 0 when gross
// -----------------------------------------------------------------------------
module fp_err_classify
    import fp_mon_pkg::*;
#(
    parameter int unsigned FP_W  = 32,
    parameter int unsigned EXP_W = 8
) (
    input  logic [FP_W-1:0] exact_res,
    input  logic [FP_W-1:0] approx_res,
    output logic            gross,
    output logic            mismatch,
    output logic [FP_W-2:0] d
);

    logic [FP_W-2:0]  mag_e;
    logic [FP_W-2:0]  mag_a;
    logic [EXP_W-1:0] exp_e;
    logic [EXP_W-1:0] exp_a;
    logic             special;
    logic             sign_diff;
    logic             both_zero;

    always_comb begin
        mag_e     = exact_res[FP_W-2:0];
        mag_a     = approx_res[FP_W-2:0];
        exp_e     = exact_res[FP_W-2 -: EXP_W];
        exp_a     = approx_res[FP_W-2 -: EXP_W];
        special   = fp_is_special(EXP_MAX_W'(exp_e), EXP_W) ||
                    fp_is_special(EXP_MAX_W'(exp_a), EXP_W);
        sign_diff = exact_res[FP_W-1] ^ approx_res[FP_W-1];
        both_zero = (mag_e == '0) && (mag_a == '0);
        gross     = special || (sign_diff && !both_zero);
        mismatch  = (exact_res != approx_res);
        d         = gross ? '0 : (FP_W-1)'(ulp_dist(DIST_W'(mag_e), DIST_W'(mag_a)));
    end

endmodule

// File: rtl/fp_mul_err_monitor.sv
// -----------------------------------------------------------------------------
// fp_mul_err_monitor
// Windowed ULP-error statistics for an exact/approximate FP multiplier pair.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a window (honoured in IDLE or DONE only)
//   win_len       : samples per window, captured on an accepted start
//   bus           : sample-pair stream (slave side)
//   busy          : window in progress (RUN or DRAIN)
//   done          : one-cycle pulse when statistics are final
//   sample_cnt    : pairs accepted
//   mismatch_cnt  : pairs with bitwise inequality (gross pairs included)
//   gross_cnt     : pairs not ULP-comparable
//   max_err       : largest ULP distance
//   sum_err       : saturating ULP distance sum
//   sum_sat       : sticky sum saturation flag
// Pipeline: stage 1 registers the pair, stage 2 folds its classification
// into the statistics.
// -----------------------------------------------------------------------------
module fp_mul_err_monitor
    import fp_mon_pkg::*;
#(
    parameter int unsigned FP_W  = 32,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned SUM_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     win_len,
    fp_mul_err_monitor_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CNT_W-1:0]     gross_cnt,
    output logic [FP_W-2:0]      max_err,
    output logic [SUM_W-1:0]     sum_err,
    output logic                 sum_sat
);

    // One bit wider than both the sum and a single distance, so the carry
    // out of SUM_W flags saturation.
    localparam int unsigned ACC_W = ((SUM_W > FP_W - 1) ? SUM_W : FP_W - 1) + 1;

    state_t           state;
    logic [CNT_W-1:0] win_len_q;
    logic             drain_cnt;
    logic             s1_valid;
    logic [FP_W-1:0]  s1_exact;
    logic [FP_W-1:0]  s1_approx;
    logic             cls_gross;
    logic             cls_mismatch;
    logic [FP_W-2:0]  cls_d;
    logic             accept;
    logic [ACC_W-1:0] sum_ext;
    logic             sum_ovf;

    assign bus.in_ready = (state == ST_RUN) && (sample_cnt < win_len_q);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state == ST_RUN) || (state == ST_DRAIN);

    fp_err_classify #(
        .FP_W  (FP_W),
        .EXP_W (EXP_W)
    ) u_classify (
        .exact_res  (s1_exact),
        .approx_res (s1_approx),
        .gross      (cls_gross),
        .mismatch   (cls_mismatch),
        .d          (cls_d)
    );

    always_comb begin
        sum_ext = ACC_W'(sum_err) + ACC_W'(cls_d);
        sum_ovf = |sum_ext[ACC_W-1:SUM_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            win_len_q    <= '0;
            drain_cnt    <= 1'b0;
            s1_valid     <= 1'b0;
            s1_exact     <= '0;
            s1_approx    <= '0;
            done         <= 1'b0;
            sample_cnt   <= '0;
            mismatch_cnt <= '0;
            gross_cnt    <= '0;
            max_err      <= '0;
            sum_err      <= '0;
            sum_sat      <= 1'b0;
        end else begin
            done     <= 1'b0;
            s1_valid <= accept;

            if (accept) begin
                s1_exact   <= bus.exact_res;
                s1_approx  <= bus.approx_res;
                sample_cnt <= sample_cnt + CNT_W'(1);
            end

            if (s1_valid) begin
                if (cls_gross || cls_mismatch) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                if (cls_gross) begin
                    gross_cnt <= gross_cnt + CNT_W'(1);
                end else begin
                    if (cls_d > max_err) begin
                        max_err <= cls_d;
                    end
                    if (sum_ovf) begin
                        sum_err <= '1;
                        sum_sat <= 1'b1;
                    end else begin
                        sum_err <= sum_ext[SUM_W-1:0];
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sample_cnt   <= '0;
                        mismatch_cnt <= '0;
                        gross_cnt    <= '0;
                        max_err      <= '0;
                        sum_err      <= '0;
                        sum_sat      <= 1'b0;
                        s1_valid     <= 1'b0;
                        drain_cnt    <= 1'b0;
                        win_len_q    <= win_len;
                        if (win_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept && (sample_cnt + CNT_W'(1) == win_len_q)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: last pair leaves stage 1, then stage 2 settles.
                    if (drain_cnt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_err_monitor
// Self-checking bench for fp_mul_err_monitor (instantiated with SUM_W=8 so the
// saturation corner is reachable). Expected window statistics are queued when
// a window is started and compared when done fires.
// -----------------------------------------------------------------------------
module tb_fp_mul_err_monitor;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = 8;

    typedef struct packed {
        logic [CNT_W-1:0] samples;
        logic [CNT_W-1:0] mism;
        logic [CNT_W-1:0] gross;
        logic [FP_W-2:0]  max;
        logic [SUM_W-1:0] sum;
        logic             sat;
    } stats_t;

    typedef struct packed {
        logic [FP_W-1:0] e;
        logic [FP_W-1:0] a;
        stats_t          exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] gross_cnt;
    logic [FP_W-2:0]  max_err;
    logic [SUM_W-1:0] sum_err;
    logic             sum_sat;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    stats_t sb_q[$];
    vec_t   vecs[11];

    always #5 clk = ~clk;

    fp_mul_err_monitor_if #(.FP_W(FP_W)) bus ();

    fp_mul_err_monitor #(
        .FP_W  (FP_W),
        .EXP_W (EXP_W),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .win_len      (win_len),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .sample_cnt   (sample_cnt),
        .mismatch_cnt (mismatch_cnt),
        .gross_cnt    (gross_cnt),
        .max_err      (max_err),
        .sum_err      (sum_err),
        .sum_sat      (sum_sat)
    );

    always @(negedge clk) if (done) done_count++;

    function automatic stats_t mk(input int s, input int m, input int g,
                                  input int mx, input int sm, input int st);
        stats_t r;
        r.samples = CNT_W'(s);
        r.mism    = CNT_W'(m);
        r.gross   = CNT_W'(g);
        r.max     = (FP_W-1)'(mx);
        r.sum     = SUM_W'(sm);
        r.sat     = st[0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_stats(input string name, input stats_t ex);
        chk({name, "_samples"}, 64'(sample_cnt),   64'(ex.samples));
        chk({name, "_mism"},    64'(mismatch_cnt), 64'(ex.mism));
        chk({name, "_gross"},   64'(gross_cnt),    64'(ex.gross));
        chk({name, "_max"},     64'(max_err),      64'(ex.max));
        chk({name, "_sum"},     64'(sum_err),      64'(ex.sum));
        chk({name, "_sat"},     64'(sum_sat),      64'(ex.sat));
    endtask

    // Called at a negedge; returns at a negedge with start low.
    task automatic start_win(input int len);
        start   = 1'b1;
        win_len = CNT_W'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [FP_W-1:0] e, input logic [FP_W-1:0] a);
        int ok;
        ok             = 0;
        bus.in_valid   = 1'b1;
        bus.exact_res  = e;
        bus.approx_res = a;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_window(input string name, input int exp_lat);
        int     lat;
        int     dc0;
        stats_t ex;
        lat = 0;
        dc0 = done_count;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_done_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) ex = sb_q.pop_front();
        else                 ex = '0;
        chk_stats(name, ex);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_done_pulses"}, 64'(done_count - dc0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int dc0;

        // Single-pair windows: {exact, approx, expected stats}
        vecs[0]  = '{32'h3F800000, 32'h3F800000, mk(1, 0, 0, 0,     0,    0)};
        vecs[1]  = '{32'h3F800000, 32'h3F800003, mk(1, 1, 0, 3,     3,    0)};
        vecs[2]  = '{32'h3F800000, 32'h3F7FFFFF, mk(1, 1, 0, 1,     1,    0)};
        vecs[3]  = '{32'h00000000, 32'h80000000, mk(1, 1, 0, 0,     0,    0)};
        vecs[4]  = '{32'h3F800000, 32'hBF800000, mk(1, 1, 1, 0,     0,    0)};
        vecs[5]  = '{32'h7FC00000, 32'h3F800000, mk(1, 1, 1, 0,     0,    0)};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, mk(1, 1, 1, 0,     0,    0)};
        vecs[7]  = '{32'hC0000000, 32'hC0000010, mk(1, 1, 0, 16,    16,   0)};
        vecs[8]  = '{32'h00000001, 32'h00000000, mk(1, 1, 0, 1,     1,    0)};
        vecs[9]  = '{32'h3F800000, 32'h3F8000C8, mk(1, 1, 0, 200,   200,  0)};
        vecs[10] = '{32'h3F800000, 32'h3F800200, mk(1, 1, 0, 'h200, 'hFF, 1)};

        rst_n          = 1'b0;
        start          = 1'b0;
        win_len        = '0;
        bus.in_valid   = 1'b1;
        bus.exact_res  = 32'h3F800000;
        bus.approx_res = 32'h40000000;

        // Reset with valid held high.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_done",     64'(done),         64'd0);
        chk_stats("rst", mk(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
        chk("idle_no_done",  64'(done_count),   64'd0);
        chk_stats("idle", mk(0, 0, 0, 0, 0, 0));
        bus.in_valid = 1'b0;

        // Table-driven single-pair windows.
        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].exp);
            start_win(1);
            send(vecs[i].e, vecs[i].a);
            check_window($sformatf("vec%0d", i), 2);
        end

        // Three-pair window.
        sb_q.push_back(mk(3, 2, 0, 3, 4, 0));
        start_win(3);
        send(32'h3F800000, 32'h3F800003);
        send(32'h40000000, 32'h40000000);
        send(32'h3F800000, 32'h3F7FFFFF);
        chk("win3_in_ready_low", 64'(bus.in_ready), 64'd0);
        check_window("win3", 2);

        // Two gross pairs.
        sb_q.push_back(mk(2, 2, 2, 0, 0, 0));
        start_win(2);
        send(32'h3F800000, 32'hBF800000);
        send(32'h7FC00000, 32'h3F800000);
        check_window("gross2", 2);

        // Zero-length window clears the previous gross stats.
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        start_win(0);
        check_window("len0", 0);

        // Saturation, then a fresh start clears the sticky flag.
        sb_q.push_back(mk(2, 2, 0, 200, 'hFF, 1));
        start_win(2);
        send(32'h3F800000, 32'h3F8000C8);
        send(32'h3F800000, 32'h3F8000C8);
        check_window("sat", 2);
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
        start_win(0);
        check_window("sat_clear", 0);

        // Random valid, start pulse mid-RUN must be ignored.
        sb_q.push_back(mk(5, 0, 0, 0, 0, 0));
        start_win(5);
        acc = 0;
        for (int cyc = 0; cyc < 200 && acc < 5; cyc++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.exact_res  = 32'h40400000;
            bus.approx_res = 32'h40400000;
            start          = (cyc == 3);
            win_len        = CNT_W'(9);
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        start        = 1'b0;
        bus.in_valid = 1'b1;
        chk("rand5_accepts",       64'(acc),          64'd5);
        chk("rand5_in_ready_low",  64'(bus.in_ready), 64'd0);
        check_window("rand5", 2);
        bus.in_valid = 1'b0;

        // Reset mid-window aborts everything.
        dc0 = done_count;
        start_win(4);
        send(32'h3F800000, 32'h3F800003);
        send(32'h3F800000, 32'h3F800003);
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",     64'(busy),         64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk_stats("abort", mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(done_count - dc0), 64'd0);
        chk("abort_idle_ready", 64'(bus.in_ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
